// File: rtl/bus_pkg.sv
// Shared definitions for the bus fabric: FSM states, error data default and
// the address-decode helper used to pick a slave index.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } bus_state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   // Slave index from the top sel_w bits of an addr_w-bit address.
   function automatic int unsigned decode_idx(input logic [31:0] addr,
                                              input int unsigned addr_w,
                                              input int unsigned sel_w);
      return (addr >> (addr_w - sel_w)) & ((32'd1 << sel_w) - 32'd1);
   endfunction

endpackage

// File: rtl/bus_rsp_timer.sv
// Saturating wait counter for an outstanding read; expired_o marks the wait
// cycle whose increment would bring the count to TIMEOUT.
module bus_rsp_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != LIMIT)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q >= LAST);

endmodule

// File: rtl/bus_fabric.sv
// Single-master interconnect: decodes the CPU address to one of N slaves,
// forwards strobes, and turns unmapped or silent accesses into error replies.
module bus_fabric
   import bus_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int N_SLAVES = 4,
   parameter int SEL_W    = 2,
   parameter int TIMEOUT  = 15,
   parameter logic [N_SLAVES-1:0] SHIFT_MASK = N_SLAVES'(1),
   parameter logic [DATA_W-1:0]   ERR_DATA   = DATA_W'(ERR_DATA_DEFAULT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            m_addr,
   input  logic                         m_rd_en,
   input  logic                         m_wr_en,
   input  logic [DATA_W-1:0]            m_wr_data,
   output logic [DATA_W-1:0]            m_rd_data,
   output logic                         m_rd_valid,
   output logic                         m_err,
   output logic                         m_busy,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wr_data,
   output logic [N_SLAVES-1:0]          s_rd_en,
   output logic [N_SLAVES-1:0]          s_wr_en,
   input  logic [N_SLAVES*DATA_W-1:0]   s_rd_data,
   input  logic [N_SLAVES-1:0]          s_rd_valid
);

   bus_state_e          state_q;
   logic [SEL_W-1:0]    idx_q;
   logic [1:0]          off_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic                rd_valid_q;
   logic                err_q;

   int unsigned         idx;
   logic                mapped;
   logic [N_SLAVES-1:0] sel_onehot;
   logic                rd_accept;
   logic                wr_unmapped;
   logic                expired;

   logic [DATA_W-1:0]   slave_data;
   logic                slave_valid;
   logic                slave_shift;
   logic [DATA_W-1:0]   aligned_data;

   assign idx    = decode_idx(32'(m_addr), ADDR_W, SEL_W);
   assign mapped = (idx < unsigned'(N_SLAVES));

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         sel_onehot[i] = (idx == unsigned'(i));
      end
   end

   assign rd_accept   = (state_q == IDLE) && m_rd_en && mapped;
   assign wr_unmapped = m_wr_en && !mapped;

   // Strobes are combinational so a slave sees the request in the issue cycle.
   assign s_rd_en   = (!rst && (state_q == IDLE) && m_rd_en) ? sel_onehot : '0;
   assign s_wr_en   = (!rst && m_wr_en) ? sel_onehot : '0;
   assign s_addr    = m_addr;
   assign s_wr_data = m_wr_data;

   always_comb begin
      slave_data  = '0;
      slave_valid = 1'b0;
      slave_shift = 1'b0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) begin
            slave_data  = s_rd_data[i*DATA_W +: DATA_W];
            slave_valid = s_rd_valid[i];
            slave_shift = SHIFT_MASK[i];
         end
      end
   end

   assign aligned_data = slave_shift ? (slave_data >> {off_q, 3'b000}) : slave_data;

   bus_rsp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_i     (clk),
      .rst_i     (rst),
      .clear_i   (rd_accept),
      .en_i      (state_q == WAIT),
      .expired_o (expired)
   );

   // Every read reply is registered on entry to RESP, so RESP is the pulse cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         off_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         err_q      <= wr_unmapped;
         case (state_q)
            IDLE: begin
               if (m_rd_en) begin
                  if (mapped) begin
                     idx_q   <= SEL_W'(idx);
                     off_q   <= m_addr[1:0];
                     state_q <= WAIT;
                  end else begin
                     rd_data_q  <= ERR_DATA;
                     rd_valid_q <= 1'b1;
                     err_q      <= 1'b1;
                     state_q    <= RESP;
                  end
               end
            end
            WAIT: begin
               if (slave_valid) begin
                  rd_data_q  <= aligned_data;
                  rd_valid_q <= 1'b1;
                  state_q    <= RESP;
               end else if (expired) begin
                  rd_data_q  <= ERR_DATA;
                  rd_valid_q <= 1'b1;
                  err_q      <= 1'b1;
                  state_q    <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_rd_data  = rd_data_q;
   assign m_rd_valid = rd_valid_q;
   assign m_err      = err_q;
   assign m_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bus_fabric.sv
// Randomised scoreboard bench for bus_fabric with three mapped slaves, so the
// top quarter of the address map is unmapped.
module tb_bus_fabric;

   localparam int          NS   = 3;
   localparam int          TO   = 15;
   localparam logic [2:0]  MASK = 3'b001;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   typedef struct {
      int          cycle;
      bit          valid;
      bit          err;
      logic [31:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [15:0]    m_addr;
   logic           m_rd_en;
   logic           m_wr_en;
   logic [31:0]    m_wr_data;
   logic [31:0]    m_rd_data;
   logic           m_rd_valid;
   logic           m_err;
   logic           m_busy;
   logic [15:0]    s_addr;
   logic [31:0]    s_wr_data;
   logic [NS-1:0]  s_rd_en;
   logic [NS-1:0]  s_wr_en;
   logic [NS*32-1:0] s_rd_data;
   logic [NS-1:0]  s_rd_valid;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];

   bus_fabric #(
      .ADDR_W(16), .DATA_W(32), .N_SLAVES(NS), .SEL_W(2), .TIMEOUT(TO),
      .SHIFT_MASK(MASK), .ERR_DATA(ERRD)
   ) dut (
      .clk(clk), .rst(rst), .m_addr(m_addr), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
      .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid),
      .m_err(m_err), .m_busy(m_busy), .s_addr(s_addr), .s_wr_data(s_wr_data),
      .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference rules: slave index is the top two address bits.
   function automatic int unsigned idxOf(input logic [15:0] a);
      return int'(a) / 16384;
   endfunction

   function automatic logic [NS-1:0] onehot(input int unsigned i);
      logic [NS-1:0] v;
      v = '0;
      if (i < NS) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] alignOf(input int unsigned i, input logic [15:0] a,
                                           input logic [31:0] d);
      int unsigned bytes;
      bytes = int'(a) % 4;
      if (MASK[i]) return d >> (8 * bytes);
      return d;
   endfunction

   // Cycle of the reply relative to the request; lat 0 or > TO means silent.
   function automatic int respCycleOf(input int unsigned i, input int lat);
      if (i >= NS) return 1;
      if (lat >= 1 && lat <= TO) return lat + 1;
      return TO + 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response pulse consumes the oldest expectation.
   always @(negedge clk) begin
      if (m_rd_valid || m_err) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedPulse", {30'd0, m_rd_valid, m_err}, 32'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("respCycle", cyc, e.cycle);
            checkOutput("respValid", {31'd0, m_rd_valid}, {31'd0, e.valid});
            checkOutput("respErr", {31'd0, m_err}, {31'd0, e.err});
            if (e.valid) checkOutput("respData", m_rd_data, e.data);
         end
      end
   end

   task automatic applyStimulus(input logic [15:0] addr, input int lat, input logic [31:0] data,
                                input int strayCyc, input int strayIdx, input bit wrDuring,
                                input logic [15:0] wAddr, input bit secondRd, input bit wrSame);
      int unsigned idx;
      int          t0;
      int          respRel;
      exp_t        e;
      idx     = idxOf(addr);
      respRel = respCycleOf(idx, lat);
      @(posedge clk); #1;
      t0         = cyc;
      m_addr     = addr;
      m_rd_en    = 1'b1;
      m_wr_en    = wrSame;
      m_wr_data  = $urandom;
      s_rd_valid = '0;
      s_rd_data  = {$urandom, $urandom, $urandom};
      e.cycle = t0 + respRel;
      e.valid = 1'b1;
      e.err   = (idx >= NS) || (lat < 1) || (lat > TO);
      e.data  = e.err ? ERRD : alignOf(idx, addr, data);
      if (idx >= NS) expQ.push_back(e);
      #1;
      checkOutput("rdStrobe", 32'(s_rd_en), 32'(onehot(idx)));
      if (wrSame) checkOutput("wrStrobeSame", 32'(s_wr_en), 32'(onehot(idx)));
      for (int k = 1; k <= respRel; k++) begin
         @(posedge clk); #1;
         m_rd_en    = 1'b0;
         m_wr_en    = 1'b0;
         s_rd_valid = '0;
         s_rd_data  = {$urandom, $urandom, $urandom};
         if (k == 1) begin
            checkOutput("busyWait", {31'd0, m_busy}, 32'd1);
            if (idx < NS) begin
               if (wrDuring) begin
                  exp_t w;
                  m_addr    = wAddr;
                  m_wr_en   = 1'b1;
                  m_wr_data = $urandom;
                  if (idxOf(wAddr) >= NS) begin
                     w.cycle = t0 + 2;
                     w.valid = 1'b0;
                     w.err   = 1'b1;
                     w.data  = '0;
                     expQ.push_back(w);
                  end
               end
               expQ.push_back(e);
            end
         end
         if (k == 2 && secondRd) begin
            m_addr  = 16'($urandom);
            m_rd_en = 1'b1;
         end
         if (idx < NS && k == lat) begin
            s_rd_valid[idx]         = 1'b1;
            s_rd_data[idx*32 +: 32] = data;
         end
         if (idx < NS && k == strayCyc) s_rd_valid[strayIdx] = 1'b1;
         #1;
         if (k == 1 && idx < NS && wrDuring)
            checkOutput("wrStrobeWait", 32'(s_wr_en), 32'(onehot(idxOf(wAddr))));
         if (k == 2 && secondRd) checkOutput("droppedRd", 32'(s_rd_en), 32'd0);
      end
      @(posedge clk); #1;
      m_rd_en    = 1'b0;
      m_wr_en    = 1'b0;
      s_rd_valid = '0;
      checkOutput("idleAfter", {31'd0, m_busy}, 32'd0);
   endtask

   task automatic applyWrite(input logic [15:0] addr);
      exp_t w;
      @(posedge clk); #1;
      m_addr    = addr;
      m_wr_en   = 1'b1;
      m_wr_data = $urandom;
      if (idxOf(addr) >= NS) begin
         w.cycle = cyc + 1;
         w.valid = 1'b0;
         w.err   = 1'b1;
         w.data  = '0;
         expQ.push_back(w);
      end
      #1;
      checkOutput("wrStrobe", 32'(s_wr_en), 32'(onehot(idxOf(addr))));
      @(posedge clk); #1;
      m_wr_en = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst        = 1'b1;
      m_addr     = '0;
      m_rd_en    = 1'b0;
      m_wr_en    = 1'b0;
      m_wr_data  = '0;
      s_rd_data  = '0;
      s_rd_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstValid", {31'd0, m_rd_valid}, 32'd0);
      checkOutput("rstErr", {31'd0, m_err}, 32'd0);
      checkOutput("rstBusy", {31'd0, m_busy}, 32'd0);
      checkOutput("rstData", m_rd_data, 32'd0);
      rst = 1'b0;

      applyStimulus(16'h0001, 1, 32'h11223344, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(16'h4000, 5, 32'hCAFEF00D, 2, 2, 1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(16'h8000, 0, 32'h0, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(16'hC000, 1, 32'h0, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);
      applyWrite(16'hC000);
      applyStimulus(16'h0000, 4, 32'h0BADF00D, 0, 0, 1'b1, 16'h4000, 1'b1, 1'b0);
      applyStimulus(16'h8003, TO, 32'hA1B2C3D4, 0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Reset in cycle 3 of a wait, then a late slave valid in cycle 4.
      @(posedge clk); #1;
      m_addr  = 16'h0000;
      m_rd_en = 1'b1;
      @(posedge clk); #1;
      m_rd_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst     = 1'b1;
      m_rd_en = 1'b1;
      m_wr_en = 1'b1;
      #1;
      checkOutput("rstRdStrobe", 32'(s_rd_en), 32'd0);
      checkOutput("rstWrStrobe", 32'(s_wr_en), 32'd0);
      m_rd_en = 1'b0;
      m_wr_en = 1'b0;
      @(posedge clk); #1;
      rst               = 1'b0;
      s_rd_valid[0]     = 1'b1;
      s_rd_data[31:0]   = 32'h55AA55AA;
      @(posedge clk); #1;
      s_rd_valid = '0;
      checkOutput("abortValid", {31'd0, m_rd_valid}, 32'd0);
      checkOutput("abortErr", {31'd0, m_err}, 32'd0);
      checkOutput("abortBusy", {31'd0, m_busy}, 32'd0);
      checkOutput("abortData", m_rd_data, 32'd0);

      for (int n = 0; n < 60; n++) begin
         logic [15:0] a, wa;
         int          lat, sc, si;
         int unsigned ix;
         if ($urandom_range(0, 4) == 0) begin
            applyWrite(16'($urandom));
         end else begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[15:14] = 2'($urandom_range(0, 2));
            ix  = idxOf(a);
            lat = $urandom_range(1, TO + 2);
            if (lat > TO) lat = 0;
            wa = 16'($urandom);
            if (lat == 1) wa[15:14] = 2'($urandom_range(0, 2));
            sc = $urandom_range(0, 4);
            si = (ix < NS) ? int'((ix + 1 + $urandom_range(0, 1)) % NS) : 0;
            applyStimulus(a, lat, $urandom, sc, si, 1'($urandom_range(0, 1)), wa,
                          1'($urandom_range(0, 1)), (ix < NS) ? 1'($urandom_range(0, 1)) : 1'b0);
         end
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queueEmpty", expQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
